// File: rtl/mna_noc_pkg.sv
// Shared definitions for the manager-side NoC adapter (flit boxer and unboxer).
// Holds the 37-bit flit layout, flit type codes, command codes and a flit
// packing helper so that both directions agree on the bit format.
package mna_noc_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int FLIT_W = 2 + 32 + CMD_W;

  // Field positions inside a flit: [36:35] type, [34:3] payload, [2:0] cmd.
  localparam int TYPE_MSB = 36;
  localparam int TYPE_LSB = 35;
  localparam int PAY_MSB  = 34;
  localparam int PAY_LSB  = 3;
  localparam int CMD_MSB  = 2;
  localparam int CMD_LSB  = 0;

  localparam logic [1:0] FLIT_HEAD      = 2'b10;  // head, data flit follows
  localparam logic [1:0] FLIT_HEAD_ONLY = 2'b11;  // single-flit packet
  localparam logic [1:0] FLIT_DATA      = 2'b01;  // data flit, always the tail

  localparam logic [CMD_W-1:0] CMD_READ  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b011;

  // Assemble a flit from its three fields.
  function automatic logic [FLIT_W-1:0] pack_flit(
    input logic [1:0]       ftype,
    input logic [31:0]      payload,
    input logic [CMD_W-1:0] cmd
  );
    logic [FLIT_W-1:0] f;
    f                   = {FLIT_W{1'b0}};
    f[TYPE_MSB:TYPE_LSB] = ftype;
    f[PAY_MSB:PAY_LSB]   = payload;
    f[CMD_MSB:CMD_LSB]   = cmd;
    return f;
  endfunction

endpackage

// File: rtl/mna_flit_boxer.sv
// mna_flit_boxer: serialises one request per input handshake into a head flit
// and an optional data flit toward the router injection port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is combinational from noc_ready)
//   in_addr, in_data      head and data payloads
//   in_cmd, in_has_data   command code, data-flit-present flag
//   noc_flit / noc_valid  registered flit output, noc_ready from downstream
//   pkt_count             wrapping count of completed packets
module mna_flit_boxer
  import mna_noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic              in_has_data,
  output logic [FLIT_W-1:0] noc_flit,
  output logic              noc_valid,
  input  logic              noc_ready,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic                has_data_q, has_data_d;
  logic [15:0]         count_q, count_d;

  logic out_hs_s;
  logic last_flit_s;
  logic pkt_done_s;
  logic in_ready_s;
  logic in_hs_s;

  // The address is not kept separately: it goes straight into the head flit
  // register, which holds it stable for as long as the head is stalled.
  assign out_hs_s    = valid_q & noc_ready;
  assign last_flit_s = (state_q == ST_DATA) | ((state_q == ST_HEAD) & ~has_data_q);
  assign pkt_done_s  = out_hs_s & last_flit_s;
  // Accepting on the last-flit handshake lets packets run back-to-back.
  assign in_ready_s  = (state_q == ST_IDLE) | pkt_done_s;
  assign in_hs_s     = in_valid & in_ready_s;

  assign in_ready  = in_ready_s;
  assign noc_flit  = flit_q;
  assign noc_valid = valid_q;
  assign pkt_count = count_q;

  // Next-state, next-flit and capture-register logic.
  always_comb begin
    state_d    = state_q;
    flit_d     = flit_q;
    valid_d    = valid_q;
    data_d     = data_q;
    cmd_d      = cmd_q;
    has_data_d = has_data_q;
    count_d    = count_q + {15'd0, pkt_done_s};

    if (in_hs_s) begin
      // New request: load its head flit, possibly replacing a finishing tail.
      state_d    = ST_HEAD;
      flit_d     = pack_flit(in_has_data ? FLIT_HEAD : FLIT_HEAD_ONLY, in_addr, in_cmd);
      valid_d    = 1'b1;
      data_d     = in_data;
      cmd_d      = in_cmd;
      has_data_d = in_has_data;
    end else if ((state_q == ST_HEAD) && out_hs_s && has_data_q) begin
      state_d = ST_DATA;
      flit_d  = pack_flit(FLIT_DATA, data_q, cmd_q);
      valid_d = 1'b1;
    end else if (pkt_done_s) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (!(state_q inside {ST_IDLE, ST_HEAD, ST_DATA})) begin
      // Unreachable encoding: recover to idle rather than lock up.
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State, output and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flit_q     <= {FLIT_W{1'b0}};
      valid_q    <= 1'b0;
      data_q     <= {DATA_W{1'b0}};
      cmd_q      <= {CMD_W{1'b0}};
      has_data_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      flit_q     <= flit_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      has_data_q <= has_data_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_mna_flit_boxer.sv
// Self-checking bench for mna_flit_boxer: directed scenarios, a randomized
// request/backpressure run against a queue-based packet model, a mid-packet
// reset and a packet counter wrap.
module tb_mna_flit_boxer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_cmd;
  logic        in_has_data;
  logic [36:0] noc_flit;
  logic        noc_valid;
  logic        noc_ready;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;
  int sent  = 0;

  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  bit          mon_en = 1'b1;

  always #5 clk = ~clk;

  mna_flit_boxer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_cmd(in_cmd), .in_has_data(in_has_data),
    .noc_flit(noc_flit), .noc_valid(noc_valid), .noc_ready(noc_ready),
    .pkt_count(pkt_count)
  );

  // Record every flit that crosses the output handshake.
  always @(posedge clk) begin
    if (mon_en && rst_n && noc_valid && noc_ready) obs_q.push_back(noc_flit);
  end

  function automatic logic [36:0] mk(input logic [1:0] t, input logic [31:0] p, input logic [2:0] c);
    return {t, p, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one packet: head (type depends on data presence) then optional data flit.
  task automatic expect_pkt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c, input logic hd);
    if (hd) begin
      exp_q.push_back(mk(2'b10, a, c));
      exp_q.push_back(mk(2'b01, d, c));
    end else begin
      exp_q.push_back(mk(2'b11, a, c));
    end
    sent++;
  endtask

  task automatic compare_flits(input string tag);
    logic [36:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 37'bx;
      chk(tag, {27'd0, o}, {27'd0, e});
    end
    chk({tag, "_extra"}, 64'(obs_q.size()), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [36:0] hold_flit;
    logic [31:0] a;
    bit          pending, drop_valid, prev_stall;
    logic [36:0] prev_flit;
    int          nreq;

    rst_n = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_data = 32'd0;
    in_cmd = 3'd0; in_has_data = 1'b0; noc_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(noc_valid), 64'd0);
    chk("rst_flit", {27'd0, noc_flit}, 64'd0);
    chk("rst_count", 64'(pkt_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;

    // Head-only read.
    step();
    in_valid = 1'b1; in_addr = 32'h0000_7FFF; in_cmd = 3'b010; in_has_data = 1'b0; noc_ready = 1'b1;
    expect_pkt(32'h0000_7FFF, 32'd0, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    chk("rd_valid", 64'(noc_valid), 64'd1);
    chk("rd_flit", {27'd0, noc_flit}, {27'd0, 37'b11_0000_0000_0000_0000_0111_1111_1111_1111_010});
    step();
    chk("rd_done_valid", 64'(noc_valid), 64'd0);
    chk("rd_count", 64'(pkt_count), 64'd1);
    compare_flits("rd_seq");

    // Write with data, no backpressure.
    in_valid = 1'b1; in_addr = 32'h0000_FFFF; in_data = 32'hA5A5_5A5A; in_cmd = 3'b011; in_has_data = 1'b1;
    expect_pkt(32'h0000_FFFF, 32'hA5A5_5A5A, 3'b011, 1'b1);
    step();
    in_valid = 1'b0;
    chk("wr_head", {27'd0, noc_flit}, {27'd0, mk(2'b10, 32'h0000_FFFF, 3'b011)});
    chk("wr_head_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("wr_data", {27'd0, noc_flit}, {27'd0, mk(2'b01, 32'hA5A5_5A5A, 3'b011)});
    chk("wr_data_valid", 64'(noc_valid), 64'd1);
    chk("wr_tail_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("wr_done_valid", 64'(noc_valid), 64'd0);
    chk("wr_count", 64'(pkt_count), 64'd2);
    compare_flits("wr_seq");

    // Same write with 5 stall cycles on each flit; inputs scrambled after capture.
    noc_ready = 1'b0; in_valid = 1'b1;
    expect_pkt(32'h0000_FFFF, 32'hA5A5_5A5A, 3'b011, 1'b1);
    step();
    in_valid = 1'b0; in_addr = 32'hDEAD_BEEF; in_data = 32'h1234_5678; in_cmd = 3'b111; in_has_data = 1'b0;
    hold_flit = mk(2'b10, 32'h0000_FFFF, 3'b011);
    for (int i = 0; i < 5; i++) begin
      chk("stall_head_flit", {27'd0, noc_flit}, {27'd0, hold_flit});
      chk("stall_head_valid", 64'(noc_valid), 64'd1);
      chk("stall_head_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    noc_ready = 1'b1; #1;
    chk("head_hs_in_ready", 64'(in_ready), 64'd0);
    step();
    noc_ready = 1'b0; #1;
    hold_flit = mk(2'b01, 32'hA5A5_5A5A, 3'b011);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data_flit", {27'd0, noc_flit}, {27'd0, hold_flit});
      chk("stall_data_valid", 64'(noc_valid), 64'd1);
      chk("stall_data_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    noc_ready = 1'b1; #1;
    chk("data_hs_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("stall_count", 64'(pkt_count), 64'd3);
    compare_flits("stall_seq");

    // Four head-only packets back to back.
    in_has_data = 1'b0; in_cmd = 3'b010; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; in_addr = a; #1;
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      expect_pkt(a, 32'd0, 3'b010, 1'b0);
      step();
      chk("b2b_valid", 64'(noc_valid), 64'd1);
      chk("b2b_flit", {27'd0, noc_flit}, {27'd0, mk(2'b11, a, 3'b010)});
    end
    in_valid = 1'b0;
    step();
    chk("b2b_count", 64'(pkt_count), 64'd7);
    compare_flits("b2b_seq");

    // Randomized requests and backpressure.
    pending = 1'b0; drop_valid = 1'b0; prev_stall = 1'b0; prev_flit = '0; nreq = 0;
    for (int c = 0; c < 1000 && (nreq < 40 || pending); c++) begin
      if (c != 0) step();
      if (prev_stall) begin
        chk("rnd_hold_flit", {27'd0, noc_flit}, {27'd0, prev_flit});
        chk("rnd_hold_valid", 64'(noc_valid), 64'd1);
      end
      if (drop_valid) begin in_valid = 1'b0; drop_valid = 1'b0; end
      if (!pending && nreq < 40 && $urandom_range(0, 2) != 0) begin
        in_addr = $urandom; in_data = $urandom; in_cmd = 3'($urandom);
        in_has_data = 1'($urandom); in_valid = 1'b1; pending = 1'b1; nreq++;
      end
      noc_ready = ($urandom_range(0, 3) != 0);
      #1;
      prev_stall = noc_valid && !noc_ready;
      prev_flit  = noc_flit;
      if (pending && in_ready) begin
        expect_pkt(in_addr, in_data, in_cmd, in_has_data);
        pending = 1'b0; drop_valid = 1'b1;
      end
    end
    if (pending) chk("rnd_timeout", 64'd1, 64'd0);
    step();
    in_valid = 1'b0; noc_ready = 1'b1;
    repeat (4) step();
    chk("rnd_idle", 64'(noc_valid), 64'd0);
    chk("rnd_count", 64'(pkt_count), 64'(sent[15:0]));
    compare_flits("rnd_seq");

    // Reset while the data flit is pending.
    in_valid = 1'b1; in_addr = 32'h1111_2222; in_data = 32'h3333_4444; in_cmd = 3'b011; in_has_data = 1'b1;
    noc_ready = 1'b1;
    exp_q.push_back(mk(2'b10, 32'h1111_2222, 3'b011));
    step();
    in_valid = 1'b0;
    step();
    noc_ready = 1'b0;
    chk("pre_rst_data", {27'd0, noc_flit}, {27'd0, mk(2'b01, 32'h3333_4444, 3'b011)});
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(noc_valid), 64'd0);
    chk("mid_rst_flit", {27'd0, noc_flit}, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_count", 64'(pkt_count), 64'd0);
    compare_flits("mid_rst_seq");
    @(negedge clk); rst_n = 1'b1; sent = 0;
    step();
    noc_ready = 1'b1; in_valid = 1'b1; in_addr = 32'h0000_00A0; in_cmd = 3'b010; in_has_data = 1'b0;
    expect_pkt(32'h0000_00A0, 32'd0, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    chk("post_rst_head", {27'd0, noc_flit}, {27'd0, mk(2'b11, 32'h0000_00A0, 3'b010)});
    step();
    chk("post_rst_count", 64'(pkt_count), 64'd1);
    compare_flits("post_rst_seq");

    // Counter wrap: drive the count to 16'hFFFF, then one more packet.
    mon_en = 1'b0;
    in_valid = 1'b1; in_has_data = 1'b0; noc_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1; in_valid = 1'b0;
    sent += 65534;
    step();
    chk("cnt_ffff", 64'(pkt_count), 64'(sent[15:0]));
    chk("cnt_ffff_const", 64'(pkt_count), 64'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; sent++;
    step();
    chk("cnt_wrap", 64'(pkt_count), 64'(sent[15:0]));
    chk("cnt_wrap_const", 64'(pkt_count), 64'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mna_flit_boxer.md
# mna_flit_boxer

Packetiser on the manager-side network adapter, in the direction opposite to the flit unboxer. It accepts one AXI4-Lite-side transaction per valid/ready handshake and serialises it into 37-bit NoC flits: a head flit carrying address and command, then an optional data flit. Output flits are registered and follow a valid/ready handshake toward the router injection port. The format is bit-compatible with what the unboxer decodes.

## Interface
- `ADDR_W`, 32, address field width; fixed at 32 by the flit format.
- `DATA_W`, 32, data field width; fixed at 32.
- `CMD_W`, 3, command code width.
- `FLIT_W`, 37, flit width; derived as 2 + 32 + `CMD_W`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when high together with `in_valid`.
- `in_addr` in 32: destination address.
- `in_data` in 32: write or response data.
- `in_cmd` in 3: command code (3'b010 read, 3'b011 write/response).
- `in_has_data` in 1: the packet includes a data flit.
- `noc_flit` out 37: flit, laid out as [36:35] type, [34:3] payload, [2:0] cmd.
- `noc_valid` out 1: flit valid.
- `noc_ready` in 1: downstream accepts the flit.
- `pkt_count` out 16: count of completed packets; wraps.

## Operation
- Flit types:
  - 2'b10: head, followed by a data flit.
  - 2'b11: head-only packet.
  - 2'b01: data flit, which is also the tail.
  - 2'b00: never emitted.
- Head flit payload = `in_addr`. Data flit payload = `in_data`. Both flits carry the same `cmd`.
- Request capture:
  - On the input handshake, `in_addr`, `in_data`, `in_cmd` and `in_has_data` are latched into internal registers.
  - Later changes on the inputs do not affect a packet in flight.
- State machine:
  - IDLE to HEAD on input handshake. The head flit is loaded into `noc_flit` and `noc_valid` is set.
  - HEAD, on output handshake:
    - with `has_data`: go to DATA and load the data flit.
    - without `has_data`: packet done, go to IDLE.
  - DATA, on output handshake: packet done, go to IDLE.
  - HEAD or DATA with no output handshake: hold state and hold `noc_flit` unchanged.
- `in_ready` = (state==IDLE) OR (the current flit is the last flit of its packet AND `noc_ready` AND `noc_valid`).
  - This is a combinational path from `noc_ready`.
  - If a new input handshake coincides with the last-flit handshake, go directly to HEAD with the new head flit loaded. There is no bubble.
- Packet done (the last-flit handshake): `pkt_count` increments by one and wraps 16'hFFFF to 0.
- `noc_valid` deasserts only when returning to IDLE with no new request accepted.

## Timing
- Reset (async assert, sync release): state IDLE, `noc_valid`=0, `noc_flit`=0, `pkt_count`=0, `in_ready`=1, internal registers 0.
- Latency: an input handshake in cycle t gives the head flit valid in cycle t+1.
  - The data flit is valid in the cycle after the head handshake.
- Best-case throughput: 1 flit per cycle.
  - Head-only packets can be sustained back-to-back at 1 packet per cycle.
  - Packets with data take 2 cycles each.
- Holding `noc_ready` low stalls indefinitely. `noc_flit` and `noc_valid` stay stable; AXI-style rule: no retraction of valid.
- Reset asserted mid-packet: the flit in flight is dropped, outputs go to reset values immediately, and there is no partial tail.
- `in_valid` with `in_ready` low: the request is not accepted and the upstream must hold it.

## Structure
- Shared package `mna_noc_pkg` holds:
  - flit type constants (`FLIT_HEAD`, `FLIT_HEAD_ONLY`, `FLIT_DATA`);
  - command codes (`CMD_READ`, `CMD_WRITE`);
  - field bit positions and `FLIT_W`.
- The unboxer uses the same package.
- No sub-module: one FSM plus capture registers. Implementation target is about 150 lines.

## Test plan
- Reset, then `in_addr`=32'h0000_7FFF, `in_cmd`=3'b010, `in_has_data`=0, `noc_ready`=1.
  - Expect one flit 37'b11_0000_0000_0000_0000_0111_1111_1111_1111_010 at t+1.
  - `pkt_count` goes to 1.
- Write with `in_addr`=32'h0000_FFFF, `in_data`=32'hA5A5_5A5A, `in_cmd`=3'b011, `in_has_data`=1.
  - Expect the head flit {10, 0000_FFFF, 011}, then the data flit {01, A5A5_5A5A, 011} on consecutive cycles.
- Same write with `noc_ready` held low for 5 cycles at each flit.
  - `noc_flit` and `noc_valid` stay stable throughout.
  - `in_ready` stays 0 until the data-flit handshake.
- Four head-only requests driven continuously with `noc_ready`=1.
  - Expect 4 flits in 4 consecutive cycles with no bubble.
  - `pkt_count`=4.
- Force `pkt_count` to 16'hFFFF via 65535 packets, or preload it in a test build; one more packet wraps it to 0.
- Assert `rst_n` low while in the DATA state.
  - `noc_valid` falls asynchronously and the state is IDLE.
  - After release, the first accepted request produces a clean head flit.
